seg7_scan_decoder: RTL and testbench

//  Recovers BCD digits from a multiplexed 7-segment display bus; the reverse direction of our BCD-to-segment encoders.

---
 rtl/seg7_scan_decoder_if.sv | 24 ++
 rtl/seg7_scan_decoder.sv | 119 +++++++++++
 tb/tb_seg7_scan_decoder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Frame handoff bundle for seg7_scan_decoder.
// Producer drives the decoded frame, consumer drives ready.
interface seg7_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   err_out;
  logic              frame_valid;
  logic              frame_ready;

  modport master (
    output bcd_out,
    output err_out,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  bcd_out,
    input  err_out,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a scanned 7-segment bus.
// One frame per full scan, handed off over valid/ready.
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      seg_in,
  input  logic [NDIG-1:0] dig_en,
  output logic            overflow,
  seg7_scan_decoder_if.master frm
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC - 1);

  logic [6:0]        seg_q, seg_p;
  logic [NDIG-1:0]   en_q, en_p;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d, done_eff;
  logic              one_hot, clr, cap;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;
  logic              bad;
  logic [4*NDIG-1:0] shd_bcd, shd_bcd_d;
  logic [NDIG-1:0]   shd_err, shd_err_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic              full, load;

  always_comb begin
    one_hot  = $onehot(en_q);
    clr      = !one_hot || ({seg_q, en_q} != {seg_p, en_p});
    cnt_d    = clr ? '0 :
               (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    // A cleared counter starts a new dwell, so the done flag
    // from the previous dwell must not block this capture.
    done_eff = done_q && !clr;
    cap      = one_hot && (cnt_d == CMAX) && !done_eff;
    done_d   = done_eff || cap;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (en_q[i]) idx = IW'(i);
    end
  end

  always_comb begin
    bad = 1'b0;
    case (seg_q)
      7'h3F:        nib = 4'h0;
      7'h06:        nib = 4'h1;
      7'h5B:        nib = 4'h2;
      7'h4F:        nib = 4'h3;
      7'h66:        nib = 4'h4;
      7'h6D:        nib = 4'h5;
      7'h7D, 7'h7C: nib = 4'h6;
      7'h07, 7'h27: nib = 4'h7;
      7'h7F:        nib = 4'h8;
      7'h6F, 7'h67: nib = 4'h9;
      7'h00:        nib = 4'hF;
      default: begin
        nib = 4'hE;
        bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    shd_bcd_d = shd_bcd;
    shd_err_d = shd_err;
    seen_d    = seen_q;
    if (cap) begin
      shd_bcd_d[4*idx +: 4] = nib;
      shd_err_d[idx]        = bad;
      seen_d[idx]           = 1'b1;
    end
    full = cap && (seen_d == '1);
    load = full && (!frm.frame_valid || frm.frame_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q           <= '0;
      seg_p           <= '0;
      en_q            <= '0;
      en_p            <= '0;
      cnt_q           <= '0;
      done_q          <= 1'b0;
      shd_bcd         <= '0;
      shd_err         <= '0;
      seen_q          <= '0;
      frm.bcd_out     <= '0;
      frm.err_out     <= '0;
      frm.frame_valid <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      seg_q   <= seg_in;
      en_q    <= dig_en;
      seg_p   <= seg_q;
      en_p    <= en_q;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      shd_bcd <= shd_bcd_d;
      shd_err <= shd_err_d;
      seen_q  <= full ? '0 : seen_d;
      if (load) begin
        frm.bcd_out     <= shd_bcd_d;
        frm.err_out     <= shd_err_d;
        frm.frame_valid <= 1'b1;
      end else if (frm.frame_valid && frm.frame_ready) begin
        frm.frame_valid <= 1'b0;
      end
      if (full && !load) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: decode table, scan corner
// cases and randomized scans against a run-length model.
module tb_seg7_scan_decoder;
  localparam int NDIG = 4;
  localparam int S    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [6:0]      seg_in = '0;
  logic [NDIG-1:0] dig_en = '0;
  logic            overflow;

  seg7_scan_decoder_if #(.NDIG(NDIG)) frm ();

  seg7_scan_decoder #(
    .NDIG      (NDIG),
    .STABLE_CYC(S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .dig_en  (dig_en),
    .overflow(overflow),
    .frm     (frm.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] nib;
    logic       err;
  } vec_t;

  vec_t vecs[16];

  logic [6:0] pats[13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h7C, 7'h07, 7'h27,
                           7'h7F, 7'h6F, 7'h67};
  int vals[13] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 7, 8, 9, 9};

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [6:0]      m_last_s;
  logic [3:0]      m_last_e;
  int              run;
  logic [3:0]      sh_nib[NDIG];
  logic            sh_err[NDIG];
  logic [NDIG-1:0] m_seen;
  logic [15:0]     m_bcd;
  logic [3:0]      m_err;
  logic            m_valid, m_ovf;
  logic [6:0]      prev_s;
  logic [3:0]      prev_e;
  int              nframes;
  logic            last_v;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void ref_decode(input logic [6:0] s,
                                     output logic [3:0] n,
                                     output logic e);
    n = 4'hE;
    e = 1'b1;
    if (s == 7'h00) begin
      n = 4'hF;
      e = 1'b0;
    end
    for (int k = 0; k < 13; k++) begin
      if (s == pats[k]) begin
        n = 4'(vals[k]);
        e = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    run      = 0;
    m_last_s = '0;
    m_last_e = '0;
    m_seen   = '0;
    for (int i = 0; i < NDIG; i++) begin
      sh_nib[i] = '0;
      sh_err[i] = 1'b0;
    end
    m_bcd   = '0;
    m_err   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    prev_s  = '0;
    prev_e  = '0;
    last_v  = 1'b0;
  endfunction

  // s/e: sample held in the input regs before this edge
  function automatic void model_step(input logic [6:0] s,
                                     input logic [3:0] e,
                                     input logic r);
    bit         oh;
    bit         full;
    bit         vold;
    logic [3:0] n;
    logic       er;
    oh = ($countones(e) == 1);
    if (oh && s == m_last_s && e == m_last_e) run++;
    else run = oh ? 1 : 0;
    m_last_s = s;
    m_last_e = e;
    vold = m_valid;
    full = 1'b0;
    if (oh && run == S) begin
      ref_decode(s, n, er);
      for (int i = 0; i < NDIG; i++) begin
        if (e[i]) begin
          sh_nib[i] = n;
          sh_err[i] = er;
          m_seen[i] = 1'b1;
        end
      end
      full = (m_seen == '1);
    end
    if (full) begin
      m_seen = '0;
      if (!vold || r) begin
        for (int i = 0; i < NDIG; i++) begin
          m_bcd[4*i +: 4] = sh_nib[i];
          m_err[i]        = sh_err[i];
        end
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (vold && r) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic tick(input logic [6:0] s, input logic [3:0] e,
                      input logic r);
    @(negedge clk);
    rst             = 1'b0;
    seg_in          = s;
    dig_en          = e;
    frm.frame_ready = r;
    @(posedge clk);
    model_step(prev_s, prev_e, r);
    prev_s = s;
    prev_e = e;
    #1;
    check("model", 32'({frm.bcd_out, frm.err_out,
                        frm.frame_valid, overflow}),
          32'({m_bcd, m_err, m_valid, m_ovf}));
    if (frm.frame_valid && !last_v) nframes++;
    last_v = frm.frame_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    seg_in          = '0;
    dig_en          = '0;
    frm.frame_ready = 1'b0;
    @(posedge clk);
    model_reset();
    nframes = 0;
    #1;
    check("reset", 32'({frm.bcd_out, frm.err_out,
                        frm.frame_valid, overflow}), 32'd0);
  endtask

  task automatic dwell(input int d, input logic [6:0] s,
                       input int n, input logic r);
    repeat (n) tick(s, 4'(1 << d), r);
  endtask

  initial begin
    vecs[0]  = '{7'h3F, 4'h0, 1'b0};
    vecs[1]  = '{7'h06, 4'h1, 1'b0};
    vecs[2]  = '{7'h5B, 4'h2, 1'b0};
    vecs[3]  = '{7'h4F, 4'h3, 1'b0};
    vecs[4]  = '{7'h66, 4'h4, 1'b0};
    vecs[5]  = '{7'h6D, 4'h5, 1'b0};
    vecs[6]  = '{7'h7D, 4'h6, 1'b0};
    vecs[7]  = '{7'h7C, 4'h6, 1'b0};
    vecs[8]  = '{7'h07, 4'h7, 1'b0};
    vecs[9]  = '{7'h27, 4'h7, 1'b0};
    vecs[10] = '{7'h7F, 4'h8, 1'b0};
    vecs[11] = '{7'h6F, 4'h9, 1'b0};
    vecs[12] = '{7'h67, 4'h9, 1'b0};
    vecs[13] = '{7'h00, 4'hF, 1'b0};
    vecs[14] = '{7'h49, 4'hE, 1'b1};
    vecs[15] = '{7'h7E, 4'hE, 1'b1};
    model_reset();
    nframes = 0;
    frm.frame_ready = 1'b0;

    // basic scan, consumer always ready
    do_reset();
    dwell(0, 7'h3F, 6, 1'b1);
    dwell(1, 7'h5B, 6, 1'b1);
    dwell(2, 7'h6F, 6, 1'b1);
    dwell(3, 7'h00, 6, 1'b1);
    check("t1_bcd", 32'(frm.bcd_out), 32'hF920);
    check("t1_err", 32'(frm.err_out), 32'h0);
    check("t1_frames", 32'(nframes), 32'd1);

    // short dwell is not captured
    do_reset();
    dwell(0, 7'h3F, 6, 1'b0);
    dwell(1, 7'h5B, 3, 1'b0);
    dwell(2, 7'h6F, 6, 1'b0);
    dwell(3, 7'h00, 6, 1'b0);
    tick(7'h00, 4'h0, 1'b0);
    check("t2_novalid", 32'(frm.frame_valid), 32'd0);
    dwell(1, 7'h5B, 4, 1'b0);
    tick(7'h00, 4'h0, 1'b0);
    check("t2_valid", 32'(frm.frame_valid), 32'd1);
    check("t2_bcd", 32'(frm.bcd_out), 32'hF920);

    // illegal pattern on digit 2
    do_reset();
    dwell(0, 7'h3F, 5, 1'b0);
    dwell(1, 7'h06, 5, 1'b0);
    dwell(2, 7'h49, 5, 1'b0);
    dwell(3, 7'h4F, 5, 1'b0);
    tick(7'h00, 4'h0, 1'b0);
    check("t3_bcd", 32'(frm.bcd_out), 32'h3E10);
    check("t3_err", 32'(frm.err_out), 32'h4);

    // dropped frame while consumer stalls
    do_reset();
    dwell(0, 7'h3F, 5, 1'b0);
    dwell(1, 7'h06, 5, 1'b0);
    dwell(2, 7'h5B, 5, 1'b0);
    dwell(3, 7'h4F, 5, 1'b0);
    dwell(0, 7'h66, 5, 1'b0);
    dwell(1, 7'h6D, 5, 1'b0);
    dwell(2, 7'h7D, 5, 1'b0);
    dwell(3, 7'h07, 5, 1'b0);
    tick(7'h00, 4'h0, 1'b0);
    check("t4_held", 32'({frm.bcd_out, frm.frame_valid}),
          32'({16'h3210, 1'b1}));
    check("t4_ovf", 32'(overflow), 32'd1);
    tick(7'h00, 4'h0, 1'b1);
    check("t4_accept", 32'(frm.frame_valid), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);

    // reset mid-frame, no stale digits afterwards
    dwell(0, 7'h66, 6, 1'b0);
    dwell(1, 7'h6D, 6, 1'b0);
    do_reset();
    dwell(2, 7'h7D, 6, 1'b0);
    dwell(3, 7'h06, 6, 1'b0);
    tick(7'h00, 4'h0, 1'b0);
    check("t6_partial", 32'(frm.frame_valid), 32'd0);
    dwell(0, 7'h7F, 6, 1'b0);
    dwell(1, 7'h07, 6, 1'b0);
    tick(7'h00, 4'h0, 1'b0);
    check("t6_frame", 32'({frm.bcd_out, frm.err_out,
                           frm.frame_valid}),
          32'({16'h1678, 4'h0, 1'b1}));

    // non-one-hot enables and a glitch mid-dwell
    do_reset();
    repeat (10) tick(7'h3F, 4'b0011, 1'b0);
    dwell(1, 7'h06, 5, 1'b0);
    dwell(2, 7'h5B, 5, 1'b0);
    dwell(3, 7'h4F, 5, 1'b0);
    check("t5_nohot", 32'(frm.frame_valid), 32'd0);
    dwell(0, 7'h3F, 2, 1'b0);
    dwell(0, 7'h7F, 1, 1'b0);
    dwell(0, 7'h3F, 3, 1'b0);
    check("t5_glitch", 32'(frm.frame_valid), 32'd0);
    dwell(0, 7'h3F, 1, 1'b0);
    check("t5_latency", 32'(frm.frame_valid), 32'd0);
    tick(7'h00, 4'h0, 1'b0);
    check("t5_frame", 32'({frm.bcd_out, frm.frame_valid}),
          32'({16'h3210, 1'b1}));

    // decode table through digit 0
    do_reset();
    for (int k = 0; k < 16; k++) begin
      dwell(0, vecs[k].seg, 5, 1'b1);
      dwell(1, 7'h3F, 5, 1'b1);
      dwell(2, 7'h3F, 5, 1'b1);
      dwell(3, 7'h3F, 5, 1'b1);
      check($sformatf("dec_%h", vecs[k].seg),
            32'({frm.bcd_out[3:0], frm.err_out[0]}),
            32'({vecs[k].nib, vecs[k].err}));
    end

    // randomized scans
    do_reset();
    for (int t = 0; t < 400; t++) begin
      int         n;
      logic [3:0] e;
      logic [6:0] s;
      if ($urandom_range(0, 99) == 0) do_reset();
      n = $urandom_range(1, 7);
      if ($urandom_range(0, 9) == 0) e = 4'($urandom_range(0, 15));
      else e = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) s = 7'($urandom_range(0, 127));
      else s = pats[$urandom_range(0, 12)];
      repeat (n) tick(s, e, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
